// File: rtl/board_pkg.sv
// Shared definitions for the board store: piece codes, manage commands,
// FSM encodings, coordinate payload and the chess start position.
package board_pkg;

    localparam int unsigned CODE_W  = 4;
    localparam int unsigned COORD_W = 4;

    localparam logic [CODE_W-1:0] EMPTY    = 4'd0;
    localparam logic [CODE_W-1:0] B_PAWN   = 4'd1;
    localparam logic [CODE_W-1:0] B_KNIGHT = 4'd2;
    localparam logic [CODE_W-1:0] B_BISHOP = 4'd3;
    localparam logic [CODE_W-1:0] B_ROOK   = 4'd4;
    localparam logic [CODE_W-1:0] B_QUEEN  = 4'd5;
    localparam logic [CODE_W-1:0] B_KING   = 4'd6;
    localparam logic [CODE_W-1:0] W_PAWN   = 4'd7;
    localparam logic [CODE_W-1:0] W_KNIGHT = 4'd8;
    localparam logic [CODE_W-1:0] W_BISHOP = 4'd9;
    localparam logic [CODE_W-1:0] W_ROOK   = 4'd10;
    localparam logic [CODE_W-1:0] W_QUEEN  = 4'd11;
    localparam logic [CODE_W-1:0] W_KING   = 4'd12;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_LOAD  = 2'b01,
        CMD_CLEAR = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    typedef enum logic {ST_SWEEP, ST_SERVE} state_e;
    typedef enum logic {MODE_LOAD, MODE_CLEAR} mode_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

    // Start position of an 8x8 board; ranks 0/1 black, ranks 6/7 white.
    function automatic logic [CODE_W-1:0] start_piece(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y);
        logic [CODE_W-1:0] black_back;
        logic [CODE_W-1:0] white_back;
        logic [CODE_W-1:0] code;
        case (x)
            4'd0, 4'd7: begin black_back = B_ROOK;   white_back = W_ROOK;   end
            4'd1, 4'd6: begin black_back = B_KNIGHT; white_back = W_KNIGHT; end
            4'd2, 4'd5: begin black_back = B_BISHOP; white_back = W_BISHOP; end
            4'd3:       begin black_back = B_QUEEN;  white_back = W_QUEEN;  end
            4'd4:       begin black_back = B_KING;   white_back = W_KING;   end
            default:    begin black_back = EMPTY;    white_back = EMPTY;    end
        endcase
        case (y)
            4'd0:    code = black_back;
            4'd1:    code = B_PAWN;
            4'd6:    code = W_PAWN;
            4'd7:    code = white_back;
            default: code = EMPTY;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the lowest requester above the last grant,
// wrapping; the pointer only moves when the grant is consumed (advance).
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant_c
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] last_q, last_d;
    logic [PTR_W-1:0] sel_c;
    logic             hit_c;

    always_comb begin
        grant_c = '0;
        sel_c   = '0;
        hit_c   = 1'b0;
        // Requesters above the pointer first, then wrap to the bottom.
        for (int unsigned j = 0; j < N; j++) begin
            if (!hit_c && req[j] && (j > 32'(last_q))) begin
                hit_c      = 1'b1;
                grant_c[j] = 1'b1;
                sel_c      = PTR_W'(j);
            end
        end
        for (int unsigned j = 0; j < N; j++) begin
            if (!hit_c && req[j]) begin
                hit_c      = 1'b1;
                grant_c[j] = 1'b1;
                sel_c      = PTR_W'(j);
            end
        end
        last_d = (advance && hit_c) ? sel_c : last_q;
    end

    always_ff @(posedge clk) begin
        if (reset) last_q <= PTR_W'(N - 1);
        else       last_q <= last_d;
    end

endmodule

// File: rtl/board_memory_arbiter.sv
// Board store: single-port piece RAM shared by N_RD round-robin readers and one
// priority writer, with built-in sweeps that load the start position or clear.
module board_memory_arbiter
    import board_pkg::*;
#(
    parameter int unsigned BOARD_W = 8,
    parameter int unsigned BOARD_H = 8,
    parameter int unsigned PIECE_W = 4,
    parameter int unsigned N_RD    = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_RD-1:0]         rd_req,
    input  logic [4*N_RD-1:0]       rd_x,
    input  logic [4*N_RD-1:0]       rd_y,
    output logic [N_RD-1:0]         rd_grant,
    output logic [N_RD-1:0]         rd_valid,
    output logic [PIECE_W*N_RD-1:0] rd_data,
    input  logic                    wr_req,
    input  logic [3:0]              wr_x,
    input  logic [3:0]              wr_y,
    input  logic [PIECE_W-1:0]      wr_data,
    output logic                    wr_ack,
    output logic                    wr_err,
    input  logic [1:0]              cmd,
    input  logic                    cmd_valid,
    output logic                    busy
);

    localparam int unsigned DEPTH  = BOARD_W * BOARD_H;
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit          IS_8X8 = (BOARD_W == 8) && (BOARD_H == 8);

    state_e                    state_q, state_d;
    mode_e                     mode_q, mode_d;
    coord_t                    sweep_q, sweep_d;
    logic                      busy_q, busy_d;
    logic                      wr_ack_q, wr_ack_d;
    logic                      wr_err_q, wr_err_d;
    logic [N_RD-1:0]           rd_grant_q, rd_grant_d;
    logic [N_RD-1:0]           rd_valid_q, rd_valid_d;
    logic [PIECE_W*N_RD-1:0]   rd_data_q, rd_data_d;
    logic                      rd_oor_q, rd_oor_d;

    logic [N_RD-1:0]           grant_c;
    logic                      rr_advance;
    coord_t                    rd_sel;
    coord_t                    wr_sel;
    logic                      ram_we, ram_re;
    logic [ADDR_W-1:0]         ram_addr;
    logic [PIECE_W-1:0]        ram_wdata;
    logic [PIECE_W-1:0]        mem_rd_data;
    logic [PIECE_W-1:0]        mem [DEPTH];

    function automatic logic in_range(input coord_t c);
        return (32'(c.x) < BOARD_W) && (32'(c.y) < BOARD_H);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input coord_t c);
        logic [8:0] lin;
        lin = 9'(c.y) * 9'(BOARD_W) + 9'(c.x);
        return ADDR_W'(lin);
    endfunction

    rr_arbiter #(.N(N_RD)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (rd_req),
        .advance (rr_advance),
        .grant_c (grant_c)
    );

    // Coordinates of whichever client the arbiter is offering this cycle.
    always_comb begin
        rd_sel   = '0;
        wr_sel.x = wr_x;
        wr_sel.y = wr_y;
        for (int unsigned i = 0; i < N_RD; i++) begin
            if (grant_c[i]) begin
                rd_sel.x = rd_x[4*i +: 4];
                rd_sel.y = rd_y[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        sweep_d    = sweep_q;
        busy_d     = busy_q;
        wr_ack_d   = 1'b0;
        wr_err_d   = 1'b0;
        rd_grant_d = '0;
        rd_valid_d = rd_grant_q;
        rd_oor_d   = 1'b0;
        rd_data_d  = rd_data_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        rr_advance = 1'b0;

        // Read data returns one cycle after the grant; other slices hold.
        for (int unsigned i = 0; i < N_RD; i++) begin
            if (rd_grant_q[i]) rd_data_d[PIECE_W*i +: PIECE_W] = rd_oor_q ? '0 : mem_rd_data;
        end

        case (state_q)
            ST_SWEEP: begin
                ram_we    = 1'b1;
                ram_addr  = addr_of(sweep_q);
                ram_wdata = (mode_q == MODE_LOAD && IS_8X8) ?
                            PIECE_W'(start_piece(sweep_q.x, sweep_q.y)) : '0;
                if (sweep_q.x == COORD_W'(BOARD_W - 1)) begin
                    sweep_d.x = '0;
                    if (sweep_q.y == COORD_W'(BOARD_H - 1)) begin
                        sweep_d.y = '0;
                        state_d   = ST_SERVE;
                        busy_d    = 1'b0;
                    end else begin
                        sweep_d.y = sweep_q.y + 4'd1;
                    end
                end else begin
                    sweep_d.x = sweep_q.x + 4'd1;
                end
            end
            ST_SERVE: begin
                if (cmd_valid && (cmd == CMD_LOAD || cmd == CMD_CLEAR)) begin
                    state_d = ST_SWEEP;
                    mode_d  = (cmd == CMD_LOAD) ? MODE_LOAD : MODE_CLEAR;
                    sweep_d = '0;
                    busy_d  = 1'b1;
                end else if (wr_req) begin
                    wr_ack_d = 1'b1;
                    if (in_range(wr_sel)) begin
                        ram_we    = 1'b1;
                        ram_addr  = addr_of(wr_sel);
                        ram_wdata = wr_data;
                    end else begin
                        wr_err_d = 1'b1;
                    end
                end else if (|rd_req) begin
                    rr_advance = 1'b1;
                    rd_grant_d = grant_c;
                    rd_oor_d   = !in_range(rd_sel);
                    ram_re     = in_range(rd_sel);
                    ram_addr   = addr_of(rd_sel);
                end
            end
            default: state_d = ST_SWEEP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_SWEEP;
            mode_q     <= MODE_LOAD;
            sweep_q    <= '0;
            busy_q     <= 1'b1;
            wr_ack_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_grant_q <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            rd_oor_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            sweep_q    <= sweep_d;
            busy_q     <= busy_d;
            wr_ack_q   <= wr_ack_d;
            wr_err_q   <= wr_err_d;
            rd_grant_q <= rd_grant_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_oor_q   <= rd_oor_d;
        end
    end

    // Single-port synchronous RAM; at most one of write/read per cycle.
    always_ff @(posedge clk) begin
        if (ram_we)      mem[ram_addr] <= ram_wdata;
        else if (ram_re) mem_rd_data   <= mem[ram_addr];
    end

    assign rd_grant = rd_grant_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign wr_ack   = wr_ack_q;
    assign wr_err   = wr_err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_board_memory_arbiter.sv
// Directed bench for board_memory_arbiter (8x8, 4-bit codes, 3 readers) with a
// read scoreboard checked by a monitor one time unit after each rising edge.
module tb_board_memory_arbiter;

    localparam int NRD = 3;
    localparam int PW  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NRD-1:0]  rd_req;
    logic [4*NRD-1:0] rd_x, rd_y;
    logic [NRD-1:0]  rd_grant, rd_valid;
    logic [PW*NRD-1:0] rd_data;
    logic            wr_req;
    logic [3:0]      wr_x, wr_y;
    logic [PW-1:0]   wr_data;
    logic            wr_ack, wr_err;
    logic [1:0]      cmd;
    logic            cmd_valid;
    logic            busy;

    typedef struct {
        int         client;
        logic [3:0] data;
    } exp_t;

    exp_t          sb[$];
    int            n_assert = 0;
    int            n_fail   = 0;
    logic [NRD-1:0] prev_grant = '0;
    logic [NRD-1:0] exp_valid;
    int            mon_c;
    exp_t          mon_e;

    board_memory_arbiter #(
        .BOARD_W(8), .BOARD_H(8), .PIECE_W(PW), .N_RD(NRD)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
        .rd_grant(rd_grant), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_err(wr_err),
        .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected start position, written out rank by rank.
    function automatic logic [3:0] exp_start(input int x, input int y);
        logic [3:0] rank0 [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
        logic [3:0] rank7 [8] = '{10, 8, 9, 11, 12, 9, 8, 10};
        if (y == 0) return rank0[x];
        if (y == 1) return 4'd1;
        if (y == 6) return 4'd7;
        if (y == 7) return rank7[x];
        return 4'd0;
    endfunction

    // Valid must follow grant by exactly one cycle unless reset intervened.
    always begin
        @(posedge clk);
        #1;
        exp_valid = reset ? '0 : prev_grant;
        check("valid_after_grant", 32'(rd_valid), 32'(exp_valid));
        if (!reset && rd_valid !== '0) begin
            mon_c = 0;
            for (int i = 0; i < NRD; i++) if (rd_valid[i]) mon_c = i;
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(rd_valid), 32'(0));
            end else begin
                mon_e = sb.pop_front();
                check("rd_client", 32'(mon_c), 32'(mon_e.client));
                check("rd_data", 32'(rd_data[PW*mon_c +: PW]), 32'(mon_e.data));
            end
        end
        prev_grant = rd_grant;
    end

    task automatic issue(input int c, input int x, input int y, input logic [3:0] exp, input bit push);
        rd_x[4*c +: 4] = 4'(x);
        rd_y[4*c +: 4] = 4'(y);
        rd_req[c] = 1'b1;
        if (push) sb.push_back('{c, exp});
    endtask

    task automatic wait_grant(input int c);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (rd_grant[c] !== 1'b1 && t < 300);
        check("grant_wait", 32'(rd_grant[c]), 32'(1));
        rd_req[c] = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_sq(input int c, input int x, input int y, input logic [3:0] exp);
        issue(c, x, y, exp, 1'b1);
        wait_grant(c);
    endtask

    task automatic write_sq(input int x, input int y, input logic [3:0] d, input logic exp_err);
        int t = 0;
        wr_x = 4'(x); wr_y = 4'(y); wr_data = d; wr_req = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (wr_ack !== 1'b1 && t < 300);
        check("wr_ack", 32'(wr_ack), 32'(1));
        check("wr_err", 32'(wr_err), 32'(exp_err));
        wr_req = 1'b0;
        @(negedge clk);
    endtask

    // Counts busy cycles from the first busy negedge; optionally pokes a LOAD mid-sweep.
    task automatic sweep_count(input int exp_cycles, input int poke_at);
        int n = 0;
        int stray = 0;
        while (busy === 1'b1 && n < 300) begin
            if (rd_grant !== '0 || wr_ack !== 1'b0) stray++;
            if (n == poke_at) begin cmd = 2'b01; cmd_valid = 1'b1; end
            else cmd_valid = 1'b0;
            n++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("busy_cycles", 32'(n), 32'(exp_cycles));
        check("grants_while_busy", 32'(stray), 32'(0));
    endtask

    task automatic start_cmd(input logic [1:0] c);
        cmd = c; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rd_req = '0; rd_x = '0; rd_y = '0;
        wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
        cmd = 2'b00; cmd_valid = 1'b0;

        // 1: reset state, 64-cycle load sweep, spot reads
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(1));
        check("rst_grant", 32'(rd_grant), 32'(0));
        check("rst_valid", 32'(rd_valid), 32'(0));
        check("rst_data", 32'(rd_data), 32'(0));
        check("rst_wr_ack", 32'(wr_ack), 32'(0));
        check("rst_wr_err", 32'(wr_err), 32'(0));
        reset = 1'b0;
        sweep_count(64, -1);
        read_sq(0, 4, 0, 4'd6);
        read_sq(1, 3, 7, 4'd11);
        read_sq(2, 2, 3, 4'd0);

        // 2: write beats a same-cycle read; read sees the new value
        wr_x = 4'd4; wr_y = 4'd4; wr_data = 4'd7; wr_req = 1'b1;
        issue(0, 4, 4, 4'd7, 1'b1);
        @(negedge clk);
        check("t2_wr_ack", 32'(wr_ack), 32'(1));
        check("t2_no_grant", 32'(rd_grant), 32'(0));
        wr_req = 1'b0;
        @(negedge clk);
        check("t2_grant0", 32'(rd_grant), 32'(3'b001));
        rd_req[0] = 1'b0;
        @(negedge clk);

        // 4: out-of-range write is acked with error and changes nothing
        write_sq(9, 2, 4'd5, 1'b1);
        read_sq(0, 1, 3, 4'd0);
        read_sq(2, 9, 2, 4'd0);

        // 3: three held requests rotate 0,1,2,0,1,2
        for (int k = 0; k < 6; k++) begin
            case (k % 3)
                0: sb.push_back('{0, 4'd4});
                1: sb.push_back('{1, 4'd10});
                default: sb.push_back('{2, 4'd7});
            endcase
        end
        issue(0, 0, 0, 4'd0, 1'b0);
        issue(1, 7, 7, 4'd0, 1'b0);
        issue(2, 4, 4, 4'd0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t3_rr_grant", 32'(rd_grant), 32'(1 << (k % 3)));
        end
        rd_req = '0;
        @(negedge clk);
        @(negedge clk);

        // reserved and none commands do nothing
        start_cmd(2'b11);
        check("cmd11_busy", 32'(busy), 32'(0));
        start_cmd(2'b00);
        check("cmd00_busy", 32'(busy), 32'(0));
        read_sq(0, 7, 0, 4'd4);

        // 5: clear mid-game stalls a held read; LOAD during sweep is ignored
        issue(1, 0, 0, 4'd0, 1'b1);
        start_cmd(2'b10);
        sweep_count(64, 10);
        wait_grant(1);
        for (int s = 0; s < 64; s++) read_sq(s % 3, s % 8, s / 8, 4'd0);
        start_cmd(2'b01);
        sweep_count(64, -1);
        read_sq(0, 0, 7, 4'd10);

        // 6a: reset while a granted read is in flight drops its valid
        issue(0, 0, 1, 4'd0, 1'b0);
        begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (rd_grant[0] !== 1'b1 && t < 300);
            check("t6_grant", 32'(rd_grant[0]), 32'(1));
        end
        reset = 1'b1; rd_req[0] = 1'b0;
        @(negedge clk);
        check("t6_no_valid", 32'(rd_valid), 32'(0));
        reset = 1'b0;
        sweep_count(64, -1);
        for (int s = 0; s < 64; s++) read_sq(s % 3, s % 8, s / 8, exp_start(s % 8, s / 8));

        // 6b: reset mid-sweep with a pending read restarts the full sweep
        write_sq(3, 0, 4'd0, 1'b0);
        issue(2, 3, 0, 4'd5, 1'b1);
        start_cmd(2'b01);
        for (int k = 0; k < 30; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sweep_count(64, -1);
        wait_grant(2);
        read_sq(1, 4, 7, 4'd12);

        @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
